// File: rtl/latch_sched_pkg.sv
// Shared definitions for the complementary-cell write scheduler:
// FSM state encoding and the pointer/counter width helper.
package latch_sched_pkg;

    // Scheduler states; encodings are fixed so they can be observed on a probe.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default requester count and the matching round-robin pointer width.
    localparam int DEF_NREQ = 4;
    localparam int PTR_W    = ptr_width(DEF_NREQ);

endpackage

// File: rtl/latch_wr_sched_rr_arbiter.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// NREQ-1 -> 0, and returns the first set requester as one-hot and as index.
module rr_arbiter
    import latch_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx,
    output logic            any
);

    logic [PW-1:0] cand_s;

    // Rotating priority scan: the first requester found at or after ptr wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = PW'((32'(ptr) + 32'(k)) % 32'(NREQ));
            if (!any && req[cand_s]) begin
                any          = 1'b1;
                win_idx      = cand_s;
                win[cand_s]  = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/latch_wr_sched.sv
// Write scheduler for a complementary storage cell (q / p = ~q).
// Requesters are arbitrated round-robin; the winner's data is captured once
// at grant and driven into the cell for HOLD cycles, followed by a one-cycle
// completion pulse. All outputs are registered.
module latch_wr_sched
    import latch_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 1,
    parameter int HOLD = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic               we,
    output logic               done,
    output logic               busy,
    output logic [DW-1:0]      q,
    output logic [DW-1:0]      p
);

    localparam int PW = ptr_width(NREQ);
    localparam int CW = ptr_width(HOLD);

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [CW-1:0]   cnt_r;
    logic [DW-1:0]   cap_r;

    logic [NREQ-1:0] win_s;
    logic [PW-1:0]   win_idx_s;
    logic            any_s;
    logic [DW-1:0]   win_data_s;
    logic [PW-1:0]   ptr_nxt_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_r),
        .win     (win_s),
        .win_idx (win_idx_s),
        .any     (any_s)
    );

    // Select the winner's data slice for capture.
    always_comb begin
        win_data_s = din[int'(win_idx_s)*DW +: DW];
    end

    // Pointer moves to the requester just after the winner, wrapping to zero.
    always_comb begin
        if (win_idx_s == PW'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_idx_s + PW'(1);
        end
    end

    // Scheduler FSM with all outputs and the cell itself held in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            ptr_r   <= '0;
            cnt_r   <= '0;
            cap_r   <= '0;
            gnt     <= '0;
            we      <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            q       <= '0;
            p       <= '1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (any_s) begin
                        gnt     <= win_s;
                        cap_r   <= win_data_s;
                        ptr_r   <= ptr_nxt_s;
                        cnt_r   <= CW'(HOLD - 1);
                        we      <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= S_HOLD;
                    end else begin
                        gnt  <= '0;
                        we   <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // The cell follows the captured value, not the live inputs.
                    q <= cap_r;
                    p <= ~cap_r;
                    if (cnt_r == CW'(0)) begin
                        gnt     <= '0;
                        we      <= 1'b0;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    gnt     <= '0;
                    we      <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    gnt     <= '0;
                    we      <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
